mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Sequencer and arbiter that shares one single-port, fixed-latency memory between the stage-one instruction fetch and the stage-three data access. It grants one access at a time, drives the memory for a fixed number of wait cycles, returns read data or a write acknowledge, and raises `stall` so the pipeline freezes while the port is busy. It sits between the pipeline stages and the memory macro, and is instantiated alongside the stage modules in the CPU top level.

## Interface
- `ADDR_W`, 16: address width.
- `DATA_W`, 16: data width; matches `uword`.
- `WAIT_CYCLES`, 2: cycles `mem_en` is held per access, ≥1.
- `FETCH_STARVE_MAX`, 4: consecutive data grants allowed while fetch waits, ≥1.

Ports:
- `clk` in 1: clock, rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `halt_sys` in 1: blocks new grants; an access already in flight still completes.
- `if_req` in 1, `if_addr` in ADDR_W: fetch request. Held until `if_gnt`.
- `if_gnt` out 1, `if_rvalid` out 1, `if_rdata` out DATA_W: fetch grant, completion pulse, read data.
- `d_req` in 1, `d_we` in 1, `d_addr` in ADDR_W, `d_wdata` in DATA_W: data request. Held until `d_gnt`.
- `d_gnt` out 1, `d_rvalid` out 1, `d_rdata` out DATA_W: data grant, completion pulse (read or write ack), read data.
- `mem_en` out 1, `mem_we` out 1, `mem_addr` out ADDR_W, `mem_wdata` out DATA_W, `mem_rdata` in DATA_W: memory port.
- `stall` out 1: pipeline freeze.

## Operation
- States:
  - IDLE: port free.
  - ACCESS: memory driven.
  - DONE: result returned.
- Transitions:
  - IDLE → ACCESS on any grant.
  - ACCESS → DONE after WAIT_CYCLES cycles, using a wait counter from 0 to WAIT_CYCLES-1.
  - DONE → IDLE unconditionally.
- Grants are combinational and are issued only in IDLE, when `halt_sys`=0 and `rst`=0.
- Arbitration in IDLE:
  - The data request wins by default.
  - Fetch wins when `if_req`=1 and `starve_cnt`==FETCH_STARVE_MAX.
  - Only one grant may be high in any cycle.
- `starve_cnt` width is clog2(FETCH_STARVE_MAX+1):
  - increments on a data grant while `if_req`=1;
  - clears on a fetch grant, or on a data grant while `if_req`=0;
  - saturates at FETCH_STARVE_MAX.
- On the grant edge, the block latches the requester ID, address, we and wdata. A fetch access is always a read.
- In ACCESS:
  - `mem_en`=1.
  - `mem_addr`, `mem_we` and `mem_wdata` come from the latched values and are stable for every ACCESS cycle.
  - `mem_rdata` is sampled on the final ACCESS edge into the owner's rdata register.
- In DONE: the owner's `*_rvalid`=1 for exactly one cycle.
  - For a read, `*_rdata` is valid in that cycle and holds its value until the next read completes.
  - For a write, `d_rdata` is unchanged.
- `stall` = (state≠IDLE) | (IDLE & (`if_req`|`d_req`) & `halt_sys`).
- A requester that keeps `req` high through DONE is treated as a new request in the following IDLE cycle.
- Reset, asynchronous, at any time including mid-access:
  - state goes to IDLE, and all counters and latched registers go to 0;
  - the in-flight access is abandoned with no `rvalid`;
  - grants are forced to 0 while `rst`=1.

## Timing
- Reset value of every output is 0:
  - `if_gnt`, `if_rvalid`, `if_rdata`;
  - `d_gnt`, `d_rvalid`, `d_rdata`;
  - `mem_en`, `mem_we`, `mem_addr`, `mem_wdata`;
  - `stall`.
- Cycle timing for a grant in cycle N:
  - `mem_en` is high in cycles N+1 through N+WAIT_CYCLES.
  - `rvalid` is high in cycle N+WAIT_CYCLES+1.
  - The next grant can be issued no earlier than N+WAIT_CYCLES+2.
- Peak throughput is one access per WAIT_CYCLES+2 cycles.
- `halt_sys` rising during ACCESS or DONE has no effect until IDLE.
- Simultaneous `if_req` and `d_req` with `starve_cnt`<max: data is granted first, and fetch is granted in the next IDLE if still requested.
- Deassertion of `req` before grant is legal: no access occurs. Request inputs are ignored outside IDLE.

## Test plan
1. Single fetch. WAIT_CYCLES=2; `if_req`=1 at cycle 0 with `if_addr`=0x0010; memory returns 0xBEEF.
   - Required: `if_gnt` at cycle 0; `mem_en`=1, `mem_we`=0, `mem_addr`=0x0010 in cycles 1–2; `if_rvalid`=1 with `if_rdata`=0xBEEF at cycle 3.
   - Required: `stall`=1 in cycles 1–3 and 0 at cycle 4.
2. Data write. `d_req`=1, `d_we`=1, `d_addr`=0x0200, `d_wdata`=0x1234 at cycle 0.
   - Required: `mem_we`=1 with address 0x0200 and data 0x1234 in cycles 1–2; `d_rvalid` at cycle 3; `d_rdata` unchanged.
3. Simultaneous requests at cycle 0.
   - Required: `d_gnt` at cycle 0, `d_rvalid` at cycle 3, `if_gnt` at cycle 4, `if_rvalid` at cycle 7.
4. Starvation. FETCH_STARVE_MAX=4; `d_req` and `if_req` held high continuously.
   - Required: four data grants at cycles 0, 4, 8, 12; fetch grant at cycle 16; data grant again at cycle 20.
5. Halt. `halt_sys`=1 with `if_req`=1 for 5 cycles.
   - Required: no grant and `stall`=1 for those cycles; grant in the cycle `halt_sys` falls.
   - Required: `halt_sys` raised during ACCESS still gives `rvalid` on schedule.
6. Reset mid-access. Assert `rst` asynchronously in cycle 2 of a read.
   - Required: all outputs are 0 immediately and no `rvalid` follows.
   - Required: after release, `if_req` is granted in the first cycle.

Source files
------------

// File: rtl/mem_arbiter.sv
// Shares one single-port, fixed-latency memory between instruction fetch and data access.
// Handshake: req is held until its combinational gnt; the access then runs WAIT_CYCLES and ends with a one-cycle rvalid.
module mem_arbiter #(
  parameter int ADDR_W           = 16,
  parameter int DATA_W           = 16,
  parameter int WAIT_CYCLES      = 2,
  parameter int FETCH_STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              halt_sys,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              stall,
  output logic [1:0]        state_dbg
);

  localparam int WC_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam int SC_W = $clog2(FETCH_STARVE_MAX + 1);
  localparam logic [WC_W-1:0] WC_LAST = WC_W'(WAIT_CYCLES - 1);
  localparam logic [SC_W-1:0] SC_MAX  = SC_W'(FETCH_STARVE_MAX);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t            state, state_nxt;
  logic [WC_W-1:0]   wait_cnt;
  logic [SC_W-1:0]   starve_cnt;
  logic              own_if;
  logic              lat_we;
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_wdata;
  logic              grant_ok;
  logic              fetch_first;
  logic              last_beat;

  always_comb begin
    state_nxt   = state;
    grant_ok    = (state == IDLE) && !halt_sys && !rst;
    // Data wins by default; fetch takes over once it has waited out the starvation limit.
    fetch_first = if_req && (starve_cnt == SC_MAX);
    if_gnt      = grant_ok && if_req && (fetch_first || !d_req);
    d_gnt       = grant_ok && d_req && !fetch_first;
    last_beat   = (state == ACCESS) && (wait_cnt == WC_LAST);
    case (state)
      IDLE:    if (if_gnt || d_gnt) state_nxt = ACCESS;
      ACCESS:  if (last_beat) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    mem_en    = (state == ACCESS);
    mem_we    = mem_en && lat_we;
    mem_addr  = mem_en ? lat_addr : '0;
    mem_wdata = mem_en ? lat_wdata : '0;
    if_rvalid = (state == DONE) && own_if;
    d_rvalid  = (state == DONE) && !own_if;
    stall     = (state != IDLE) || ((if_req || d_req) && halt_sys);
    state_dbg = state;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      wait_cnt   <= '0;
      starve_cnt <= '0;
      own_if     <= 1'b0;
      lat_we     <= 1'b0;
      lat_addr   <= '0;
      lat_wdata  <= '0;
      if_rdata   <= '0;
      d_rdata    <= '0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= ((state == ACCESS) && !last_beat) ? wait_cnt + 1'b1 : '0;
      if (if_gnt) begin
        own_if     <= 1'b1;
        lat_addr   <= if_addr;
        lat_we     <= 1'b0;
        lat_wdata  <= '0;
        starve_cnt <= '0;
      end else if (d_gnt) begin
        own_if    <= 1'b0;
        lat_addr  <= d_addr;
        lat_we    <= d_we;
        lat_wdata <= d_wdata;
        if (!if_req)
          starve_cnt <= '0;
        else if (starve_cnt != SC_MAX)
          starve_cnt <= starve_cnt + 1'b1;
      end
      // Reads land in the owner's register; writes leave both rdata registers alone.
      if (last_beat && !lat_we) begin
        if (own_if) if_rdata <= mem_rdata;
        else        d_rdata  <= mem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a small memory model and rvalid scoreboards.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        halt_sys = 1'b0;
  logic        if_req = 1'b0;
  logic [15:0] if_addr = '0;
  logic        if_gnt, if_rvalid;
  logic [15:0] if_rdata;
  logic        d_req = 1'b0;
  logic        d_we = 1'b0;
  logic [15:0] d_addr = '0;
  logic [15:0] d_wdata = '0;
  logic        d_gnt, d_rvalid;
  logic [15:0] d_rdata;
  logic        mem_en, mem_we;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;
  logic        stall;
  logic [1:0]  state_dbg;

  int total = 0;
  int bad   = 0;
  logic [15:0] if_exp_q[$];
  logic [15:0] d_exp_q[$];
  logic [15:0] d_rdata_exp = '0;

  logic [15:0] mem_model [256];
  bit          mem_loaded = 1'b0;

  always #5 clk = ~clk;

  mem_arbiter #(
    .ADDR_W(16), .DATA_W(16), .WAIT_CYCLES(2), .FETCH_STARVE_MAX(4)
  ) dut (
    .clk(clk), .rst(rst), .halt_sys(halt_sys),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .stall(stall), .state_dbg(state_dbg)
  );

  function automatic logic [15:0] init_val(input logic [7:0] a);
    return (a == 8'h10) ? 16'hBEEF : {a, ~a};
  endfunction

  assign mem_rdata = mem_model[mem_addr[7:0]];

  always @(posedge clk) begin
    if (!mem_loaded) begin
      for (int i = 0; i < 256; i++) mem_model[i] = init_val(8'(i));
      mem_loaded = 1'b1;
    end else if (mem_en && mem_we) begin
      mem_model[mem_addr[7:0]] = mem_wdata;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Completion scoreboard: every rvalid must match the oldest expected result.
  always @(negedge clk) begin
    if (if_rvalid) begin
      if (if_exp_q.size() == 0) chk("if_rvalid_unexpected", 1, 0);
      else chk("if_rdata", if_rdata, if_exp_q.pop_front());
    end
    if (d_rvalid) begin
      if (d_exp_q.size() == 0) chk("d_rvalid_unexpected", 1, 0);
      else chk("d_rdata", d_rdata, d_exp_q.pop_front());
    end
  end

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic cyc(input string tag, input logic ig, input logic dg, input logic me,
                     input logic ir, input logic dr, input logic st);
    @(negedge clk);
    chk({tag, ".if_gnt"}, if_gnt, ig);
    chk({tag, ".d_gnt"}, d_gnt, dg);
    chk({tag, ".mem_en"}, mem_en, me);
    chk({tag, ".if_rvalid"}, if_rvalid, ir);
    chk({tag, ".d_rvalid"}, d_rvalid, dr);
    chk({tag, ".stall"}, stall, st);
    adv();
  endtask

  task automatic acc(input string tag, input logic we, input logic [15:0] addr, input logic [15:0] wdata);
    @(negedge clk);
    chk({tag, ".mem_en"}, mem_en, 1);
    chk({tag, ".gnt"}, {if_gnt, d_gnt}, 0);
    chk({tag, ".rvalid"}, {if_rvalid, d_rvalid}, 0);
    chk({tag, ".stall"}, stall, 1);
    chk({tag, ".mem_we"}, mem_we, we);
    chk({tag, ".mem_addr"}, mem_addr, addr);
    if (we) chk({tag, ".mem_wdata"}, mem_wdata, wdata);
    adv();
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".gnt"}, {if_gnt, d_gnt}, 0);
    chk({tag, ".rvalid"}, {if_rvalid, d_rvalid}, 0);
    chk({tag, ".if_rdata"}, if_rdata, 0);
    chk({tag, ".d_rdata"}, d_rdata, 0);
    chk({tag, ".mem_ctl"}, {mem_en, mem_we}, 0);
    chk({tag, ".mem_addr"}, mem_addr, 0);
    chk({tag, ".mem_wdata"}, mem_wdata, 0);
    chk({tag, ".stall"}, stall, 0);
    chk({tag, ".state"}, state_dbg, 0);
  endtask

  initial begin
    // Reset: everything 0 and no grant even with a request pending.
    if_req = 1'b1;
    if_addr = 16'h0010;
    @(negedge clk);
    chk_zero("reset");
    adv();
    rst = 1'b0;

    // Single fetch.
    if_exp_q.push_back(16'hBEEF);
    cyc("t1_c0", 1, 0, 0, 0, 0, 0);
    if_req = 1'b0;
    acc("t1_c1", 0, 16'h0010, 0);
    acc("t1_c2", 0, 16'h0010, 0);
    cyc("t1_c3", 0, 0, 0, 1, 0, 1);
    cyc("t1_c4", 0, 0, 0, 0, 0, 0);

    // Data write, then read back through the same port.
    d_req = 1'b1; d_we = 1'b1; d_addr = 16'h0200; d_wdata = 16'h1234;
    d_exp_q.push_back(d_rdata_exp);
    cyc("t2_c0", 0, 1, 0, 0, 0, 0);
    d_req = 1'b0; d_we = 1'b0; d_wdata = 16'h0;
    acc("t2_c1", 1, 16'h0200, 16'h1234);
    acc("t2_c2", 1, 16'h0200, 16'h1234);
    cyc("t2_c3", 0, 0, 0, 0, 1, 1);
    d_req = 1'b1;
    d_rdata_exp = 16'h1234;
    d_exp_q.push_back(d_rdata_exp);
    cyc("t2r_c0", 0, 1, 0, 0, 0, 0);
    d_req = 1'b0;
    acc("t2r_c1", 0, 16'h0200, 0);
    acc("t2r_c2", 0, 16'h0200, 0);
    cyc("t2r_c3", 0, 0, 0, 0, 1, 1);

    // Simultaneous requests: data first, fetch in the next IDLE.
    if_req = 1'b1; if_addr = 16'h0020;
    d_req = 1'b1; d_addr = 16'h0030;
    d_rdata_exp = init_val(8'h30);
    d_exp_q.push_back(d_rdata_exp);
    if_exp_q.push_back(init_val(8'h20));
    cyc("t3_c0", 0, 1, 0, 0, 0, 0);
    d_req = 1'b0;
    acc("t3_c1", 0, 16'h0030, 0);
    acc("t3_c2", 0, 16'h0030, 0);
    cyc("t3_c3", 0, 0, 0, 0, 1, 1);
    cyc("t3_c4", 1, 0, 0, 0, 0, 0);
    if_req = 1'b0;
    acc("t3_c5", 0, 16'h0020, 0);
    acc("t3_c6", 0, 16'h0020, 0);
    cyc("t3_c7", 0, 0, 0, 1, 0, 1);

    // Starvation: four data grants, then fetch, then data again.
    if_req = 1'b1; if_addr = 16'h0050;
    d_req = 1'b1; d_addr = 16'h0040;
    for (int g = 0; g < 6; g++) begin
      if (g == 4) begin
        if_exp_q.push_back(init_val(8'h50));
        cyc($sformatf("t4_g%0d", g), 1, 0, 0, 0, 0, 0);
        acc($sformatf("t4_a%0d", g), 0, 16'h0050, 0);
        acc($sformatf("t4_b%0d", g), 0, 16'h0050, 0);
        cyc($sformatf("t4_d%0d", g), 0, 0, 0, 1, 0, 1);
      end else begin
        d_rdata_exp = init_val(8'h40);
        d_exp_q.push_back(d_rdata_exp);
        cyc($sformatf("t4_g%0d", g), 0, 1, 0, 0, 0, 0);
        acc($sformatf("t4_a%0d", g), 0, 16'h0040, 0);
        acc($sformatf("t4_b%0d", g), 0, 16'h0040, 0);
        cyc($sformatf("t4_d%0d", g), 0, 0, 0, 0, 1, 1);
      end
    end
    if_req = 1'b0; d_req = 1'b0;

    // Halt blocks grants; halt raised mid-access does not delay completion.
    halt_sys = 1'b1; if_req = 1'b1; if_addr = 16'h0060;
    for (int i = 0; i < 5; i++) cyc($sformatf("t5_h%0d", i), 0, 0, 0, 0, 0, 1);
    halt_sys = 1'b0;
    if_exp_q.push_back(init_val(8'h60));
    cyc("t5_c0", 1, 0, 0, 0, 0, 0);
    if_req = 1'b0; halt_sys = 1'b1;
    acc("t5_c1", 0, 16'h0060, 0);
    acc("t5_c2", 0, 16'h0060, 0);
    cyc("t5_c3", 0, 0, 0, 1, 0, 1);
    cyc("t5_c4", 0, 0, 0, 0, 0, 0);
    halt_sys = 1'b0;

    // Reset mid-access: abandoned read, then an immediate grant after release.
    if_req = 1'b1; if_addr = 16'h0070;
    cyc("t6_c0", 1, 0, 0, 0, 0, 0);
    if_req = 1'b0;
    acc("t6_c1", 0, 16'h0070, 0);
    #2;
    rst = 1'b1;
    #1;
    chk_zero("t6_async");
    cyc("t6_c2", 0, 0, 0, 0, 0, 0);
    cyc("t6_c3", 0, 0, 0, 0, 0, 0);
    rst = 1'b0;
    if_req = 1'b1; if_addr = 16'h0080;
    if_exp_q.push_back(init_val(8'h80));
    cyc("t6_r0", 1, 0, 0, 0, 0, 0);
    if_req = 1'b0;
    acc("t6_r1", 0, 16'h0080, 0);
    acc("t6_r2", 0, 16'h0080, 0);
    cyc("t6_r3", 0, 0, 0, 1, 0, 1);
    cyc("t6_r4", 0, 0, 0, 0, 0, 0);

    chk("if_q_drained", if_exp_q.size(), 0);
    chk("d_q_drained", d_exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
